// File: rtl/phase_unwrap_scheduler.sv
// Shares one phase-unwrap datapath among NCH channels: a round-robin arbiter feeds a 4-state FSM
// that turns 3Q21 wrapped phase into 11Q21 unwrapped phase, with per-channel wrap-count state.
module phase_unwrap_scheduler #(
   parameter int NCH                = 2,
   parameter int S_AXIS_TDATA_WIDTH = 24,
   parameter int M_AXIS_TDATA_WIDTH = 32,
   parameter int WRAP_MAX           = 160
) (
   input  logic                              aclk,
   input  logic                              aresetn,
   input  logic [NCH*S_AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
   input  logic [NCH-1:0]                    S_AXIS_tvalid,
   output logic [NCH-1:0]                    S_AXIS_tready,
   input  logic [NCH-1:0]                    enable,
   output logic [M_AXIS_TDATA_WIDTH-1:0]     M_AXIS_tdata,
   output logic [1:0]                        M_AXIS_tid,
   output logic                              M_AXIS_tvalid,
   input  logic                              M_AXIS_tready,
   output logic [NCH-1:0]                    sat_flag
);

   // state  | meaning
   // IDLE   | waiting for a pending channel; grants one round-robin and latches its sample
   // DIFF   | dp = p - prev[ch] (25-bit), samples enable[ch]
   // ACC    | updates the channel's wrap count/state and registers the unwrapped output
   // OUT    | holds the output until the downstream handshake
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_DIFF = 2'd1;
   localparam logic [1:0] S_ACC  = 2'd2;
   localparam logic [1:0] S_OUT  = 2'd3;

   localparam int SW = S_AXIS_TDATA_WIDTH;
   localparam int MW = M_AXIS_TDATA_WIDTH;
   localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

   localparam logic signed [SW:0]   PI_Q21     = (SW+1)'(6588397);
   localparam logic signed [MW-1:0] TWO_PI_Q21 = MW'(13176795);
   localparam logic signed [8:0]    WMAX       = 9'(WRAP_MAX);

   logic [1:0]           r_state;
   logic [NCH-1:0]       r_pending;
   logic [NCH-1:0]       r_run;
   logic [NCH-1:0]       r_sat;
   logic [SW-1:0]        r_hold [NCH];
   logic signed [SW-1:0] r_prev [NCH];
   logic signed [8:0]    r_wrap [NCH];
   logic [CW-1:0]        r_last;
   logic [CW-1:0]        r_ch;
   logic signed [SW-1:0] r_p;
   logic signed [SW:0]   r_dp;
   logic                 r_en;
   logic [MW-1:0]        r_tdata;
   logic [1:0]           r_tid;
   logic                 r_tvalid;

   logic                 w_found;
   logic [CW-1:0]        w_gnt;
   logic signed [8:0]    w_wrap_nxt;
   logic                 w_sat_set;
   logic signed [MW-1:0] w_p_ext;
   logic signed [MW-1:0] w_wrap_ext;
   logic signed [MW-1:0] w_out;

   assign S_AXIS_tready = aresetn ? ~r_pending : '0;
   assign M_AXIS_tdata  = r_tdata;
   assign M_AXIS_tid    = r_tid;
   assign M_AXIS_tvalid = r_tvalid;
   assign sat_flag      = r_sat;

   // First pending channel at or after last_grant+1, wrapping modulo NCH.
   always_comb begin
      w_found = 1'b0;
      w_gnt   = '0;
      for (int k = 1; k <= NCH; k++) begin
         if (!w_found && r_pending[CW'((int'(r_last) + k) % NCH)]) begin
            w_found = 1'b1;
            w_gnt   = CW'((int'(r_last) + k) % NCH);
         end
      end
   end

   always_comb begin
      w_wrap_nxt = '0;
      w_sat_set  = 1'b0;
      if (r_en && r_run[r_ch]) begin
         w_wrap_nxt = r_wrap[r_ch];
         if (r_dp > PI_Q21) begin
            if (r_wrap[r_ch] == -WMAX) w_sat_set  = 1'b1;
            else                       w_wrap_nxt = r_wrap[r_ch] - 9'sd1;
         end else if (r_dp < -PI_Q21) begin
            if (r_wrap[r_ch] == WMAX)  w_sat_set  = 1'b1;
            else                       w_wrap_nxt = r_wrap[r_ch] + 9'sd1;
         end
      end
      w_p_ext    = {{(MW-SW){r_p[SW-1]}}, r_p};
      w_wrap_ext = {{(MW-9){w_wrap_nxt[8]}}, w_wrap_nxt};
      w_out      = w_p_ext + w_wrap_ext * TWO_PI_Q21;
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_state   <= S_IDLE;
         r_pending <= '0;
         r_run     <= '0;
         r_sat     <= '0;
         for (int i = 0; i < NCH; i++) begin
            r_hold[i] <= '0;
            r_prev[i] <= '0;
            r_wrap[i] <= '0;
         end
         r_last   <= CW'(NCH - 1);
         r_ch     <= '0;
         r_p      <= '0;
         r_dp     <= '0;
         r_en     <= 1'b0;
         r_tdata  <= '0;
         r_tid    <= '0;
         r_tvalid <= 1'b0;
      end else begin
         // A pending channel has tready low, so capture never collides with the grant clear.
         for (int i = 0; i < NCH; i++) begin
            if (S_AXIS_tvalid[i] && !r_pending[i]) begin
               r_pending[i] <= 1'b1;
               r_hold[i]    <= S_AXIS_tdata[i*SW +: SW];
            end
         end
         case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  r_pending[w_gnt] <= 1'b0;
                  r_ch             <= w_gnt;
                  r_last           <= w_gnt;
                  r_p              <= r_hold[w_gnt];
                  r_state          <= S_DIFF;
               end
            end
            S_DIFF: begin
               r_dp    <= {r_p[SW-1], r_p} - {r_prev[r_ch][SW-1], r_prev[r_ch]};
               r_en    <= enable[r_ch];
               r_state <= S_ACC;
            end
            S_ACC: begin
               r_wrap[r_ch] <= w_wrap_nxt;
               r_prev[r_ch] <= r_p;
               if (!r_en) begin
                  r_run[r_ch] <= 1'b0;
                  r_sat[r_ch] <= 1'b0;
               end else begin
                  r_run[r_ch] <= 1'b1;
                  if (w_sat_set) r_sat[r_ch] <= 1'b1;
               end
               r_tdata  <= w_out;
               r_tid    <= 2'(r_ch);
               r_tvalid <= 1'b1;
               r_state  <= S_OUT;
            end
            S_OUT: begin
               if (M_AXIS_tready) begin
                  r_tvalid <= 1'b0;
                  r_state  <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
